l_func_divider: RTL and testbench

Parametrised, streaming long divider for the Paillier L-function path. Operands arrive over one BLOCK-wide input channel, MSB-first; the block computes either a/d or L(a) = (a-1)/d with a one-bit-per-cycle restoring loop. It returns quotient and remainder LSB-first over a BLOCK-wide output channel. Unlike the earlier divider, it adds ready/valid backpressure, a mode select, a remainder output and error flags.

---
 rtl/l_func_divider.sv | 234 +++++++++++++++++++++++
 tb/tb_l_func_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/l_func_divider.sv
// Streaming restoring long divider for the Paillier L-function: loads a and d
// MSB-first, computes a/d or (a-1)/d one bit per cycle, returns q and r LSB-first.
module l_func_divider #(
  parameter int N     = 4096,
  parameter int M     = 2048,
  parameter int BLOCK = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLOCK-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLOCK-1:0] out_quot,
  output logic [BLOCK-1:0] out_rem,
  output logic             out_last,
  output logic             busy,
  output logic             err_dz,
  output logic             err_ovf,
  output logic             err_l
);

  // Handshakes: a beat moves on a rising edge where valid && ready were both
  // high before it; a raised valid and its payload stay put until that edge.

  localparam int A_BEATS = N / BLOCK;
  localparam int D_BEATS = M / BLOCK;
  localparam int CW      = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_D = 3'd2,
    PREP   = 3'd3,
    DIV    = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d;
  logic [M-1:0]     d_q, d_d;
  logic [N-1:0]     q_q, q_d;
  logic [M:0]       r_q, r_d;
  logic             err_dz_q, err_dz_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_l_q, err_l_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [BLOCK-1:0] out_quot_q, out_quot_d;
  logic [BLOCK-1:0] out_rem_q, out_rem_d;

  logic [M:0]       r_shift;
  logic [M:0]       d_ext;
  logic             q_bit;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    d_d       = d_q;
    q_d       = q_q;
    r_d       = r_q;
    err_dz_d  = err_dz_q;
    err_ovf_d = err_ovf_q;
    err_l_d   = err_l_q;
    r_shift   = '0;
    d_ext     = {1'b0, d_q};
    q_bit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_A;
          mode_d    = mode;
          cnt_d     = '0;
          err_dz_d  = 1'b0;
          err_ovf_d = 1'b0;
          err_l_d   = 1'b0;
        end
      end

      LOAD_A: begin
        if (in_valid) begin
          a_d = N'({a_q, in_data});
          if (cnt_q == CW'(A_BEATS - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_D;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      LOAD_D: begin
        if (in_valid) begin
          d_d = M'({d_q, in_data});
          if (cnt_q == CW'(D_BEATS - 1)) begin
            cnt_d   = '0;
            state_d = PREP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      PREP: begin
        // a_q is replaced by a' here and then consumed MSB-first by DIV.
        a_d   = a_q - {{(N-1){1'b0}}, mode_q};
        cnt_d = '0;
        if (mode_q && (a_q == '0)) begin
          err_l_d = 1'b1;
          q_d     = '0;
          r_d     = '0;
          state_d = OUT;
        end else if (d_q == '0) begin
          err_dz_d = 1'b1;
          q_d      = '1;
          r_d      = {1'b0, a_d[M-1:0]};
          state_d  = OUT;
        end else begin
          q_d     = '0;
          r_d     = '0;
          state_d = DIV;
        end
      end

      DIV: begin
        // r < d < 2^M holds between iterations, so r[M] is always zero here.
        r_shift = {r_q[M-1:0], a_q[N-1]};
        a_d     = a_q << 1;
        if (r_shift >= d_ext) begin
          r_d   = r_shift - d_ext;
          q_bit = 1'b1;
        end else begin
          r_d   = r_shift;
          q_bit = 1'b0;
        end
        q_d = N'({q_q, q_bit});
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      OUT: begin
        if (out_ready) begin
          q_d = q_q >> BLOCK;
          r_d = r_q >> BLOCK;
          if (cnt_q == CW'(D_BEATS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == OUT) && (state_q != OUT)) begin
      err_ovf_d = ((q_d >> M) != '0);
    end

    // Output beat registers track the low slice of q/r, so they hold while stalled.
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_D);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);
    out_quot_d  = out_valid_d ? q_d[BLOCK-1:0] : '0;
    out_rem_d   = out_valid_d ? r_d[BLOCK-1:0] : '0;
    out_last_d  = out_valid_d && (cnt_d == CW'(D_BEATS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      err_dz_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_l_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      d_q         <= d_d;
      q_q         <= q_d;
      r_q         <= r_d;
      err_dz_q    <= err_dz_d;
      err_ovf_q   <= err_ovf_d;
      err_l_q     <= err_l_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign err_dz    = err_dz_q;
  assign err_ovf   = err_ovf_q;
  assign err_l     = err_l_q;

endmodule

// File: tb/tb_l_func_divider.sv
// Directed bench for l_func_divider at N=16, M=8, BLOCK=4 with hand-computed
// quotient/remainder beats, error flags, latency, backpressure and reset abort.
module tb_l_func_divider;

  localparam int N     = 16;
  localparam int M     = 8;
  localparam int BLOCK = 4;
  localparam int W     = 1 + 2 * BLOCK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [BLOCK-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLOCK-1:0] out_quot;
  logic [BLOCK-1:0] out_rem;
  logic             out_last;
  logic             busy;
  logic             err_dz;
  logic             err_ovf;
  logic             err_l;

  int n_checks;
  int n_fail;

  // Expected output beats, each packed as {last, rem, quot}.
  logic [W-1:0] exp_q[$];

  l_func_divider #(.N(N), .M(M), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .out_last  (out_last),
    .busy      (busy),
    .err_dz    (err_dz),
    .err_ovf   (err_ovf),
    .err_l     (err_l)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [BLOCK-1:0] data, input bit gaps);
    int waited;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        in_data = BLOCK'($urandom_range(0, 15));
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = data;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = BLOCK'($urandom_range(0, 15));
  endtask

  task automatic load_job(input logic m, input logic [N-1:0] a, input logic [M-1:0] d,
                          input bit gaps);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    for (int i = 0; i < N / BLOCK; i++) drive_beat(a[N-1-BLOCK*i -: BLOCK], gaps);
    for (int i = 0; i < M / BLOCK; i++) drive_beat(d[M-1-BLOCK*i -: BLOCK], gaps);
  endtask

  task automatic run_job(input string name, input logic m, input logic [N-1:0] a,
                         input logic [M-1:0] d, input logic [M-1:0] eq, input logic [M-1:0] er,
                         input logic edz, input logic eovf, input logic el, input int elat,
                         input bit gaps, input int stall0);
    int lat;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    load_job(m, a, d, gaps);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq({name, "_latency"}, 64'(lat), 64'(elat));
    if (out_valid) begin
      check_eq({name, "_err_dz"}, 64'(err_dz), 64'(edz));
      check_eq({name, "_err_ovf"}, 64'(err_ovf), 64'(eovf));
      check_eq({name, "_err_l"}, 64'(err_l), 64'(el));
      for (int k = 0; k < M / BLOCK; k++)
        exp_q.push_back({(k == M / BLOCK - 1), er[BLOCK*k +: BLOCK], eq[BLOCK*k +: BLOCK]});
      for (int k = 0; k < M / BLOCK; k++) begin
        if (k == 0 && stall0 > 0) begin
          out_ready = 1'b0;
          for (int s = 0; s < stall0; s++) begin
            tick();
            check_eq({name, "_stall_valid"}, 64'(out_valid), 64'd1);
            check_eq({name, "_stall_beat"}, 64'({out_last, out_rem, out_quot}), 64'(exp_q[0]));
          end
        end
        out_ready = 1'b1;
        got = {out_last, out_rem, out_quot};
        exp = exp_q.pop_front();
        check_eq({name, "_beat"}, 64'(got), 64'(exp));
        check_eq({name, "_beat_valid"}, 64'(out_valid), 64'd1);
        tick();
      end
      out_ready = 1'b0;
      check_eq({name, "_busy_after"}, 64'(busy), 64'd0);
      check_eq({name, "_valid_after"}, 64'(out_valid), 64'd0);
      check_eq({name, "_ovf_held"}, 64'(err_ovf), 64'(eovf));
    end
    exp_q.delete();
  endtask

  // ---------------- main sequence and final report ----------------
  initial begin
    int seen_valid;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 64'({in_ready, out_valid, out_last, busy, err_dz, err_ovf, err_l}), 64'd0);
    check_eq("rst_data", 64'({out_quot, out_rem}), 64'd0);
    rst_n = 1'b1;
    tick();

    // 0x1234 / 0x56 = 0x36 r 0x10
    run_job("s1", 1'b0, 16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 1'b0, 18, 1'b0, 0);
    // (0x1235 - 1) / 0x56 = 0x36 r 0x10
    run_job("s2", 1'b1, 16'h1235, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 1'b0, 18, 1'b0, 0);
    // 0xFFFF / 2 = 0x7FFF r 1 -> low byte 0xFF, quotient overflows M bits
    run_job("s3", 1'b0, 16'hFFFF, 8'h02, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 18, 1'b0, 0);
    // divide by zero: q all ones (high half nonzero -> ovf), r = a[7:0]
    run_job("s4dz", 1'b0, 16'hABCD, 8'h00, 8'hFF, 8'hCD, 1'b1, 1'b1, 1'b0, 2, 1'b0, 0);
    // L(0): error, q = r = 0
    run_job("s4l", 1'b1, 16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0);
    // 0x0100 / 0x07 = 0x24 r 0x04, start accepted right after the previous job
    run_job("s4b", 1'b0, 16'h0100, 8'h07, 8'h24, 8'h04, 1'b0, 1'b0, 1'b0, 18, 1'b0, 0);
    // scenario 1 again with input gaps and a 5-cycle stall on beat 0
    run_job("s5", 1'b0, 16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 1'b0, 18, 1'b1, 5);

    // reset during DIV aborts the job
    load_job(1'b0, 16'h1234, 8'h56, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("abort_state", 64'({in_ready, out_valid, out_last, busy, err_dz, err_ovf, err_l}), 64'd0);
    check_eq("abort_data", 64'({out_quot, out_rem}), 64'd0);
    tick();
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (25) begin
      tick();
      if (out_valid || busy) seen_valid++;
    end
    check_eq("abort_no_beats", 64'(seen_valid), 64'd0);
    run_job("post_rst", 1'b0, 16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 1'b0, 18, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
